vita49_unpack: RTL and testbench
================================

Name: vita49_unpack

Overview:
- Receive-side counterpart of the VITA49 packer. Accepts big-endian VITA49 IF Data packets with stream ID (type 0001) on an AXI-Stream slave.
- Parses and strips the header, stream ID, optional integer timestamp, fractional timestamp and optional trailer.
- Forwards byte-swapped payload words on an AXI-Stream master, with TLAST on the last payload word of each packet.
- Sits between the DMA/transport ingress and the sample sink. Publishes timestamps, sequence and error status to the processor.

Parameters:
PKT_TYPE, 4'b0001, header packet-type value accepted; any other type is dropped.

Ports:
AXIS_ACLK  in  1  clock
AXIS_ARESETN  in  1  asynchronous active-low reset
S_AXIS_TDATA  in  32  packet word, VITA49 big-endian byte order
S_AXIS_TVALID  in  1  slave valid
S_AXIS_TLAST  in  1  last word of packet
S_AXIS_TREADY  out  1  slave ready
M_AXIS_TDATA  out  32  payload word, byte-swapped (passthrough: raw)
M_AXIS_TVALID  out  1  master valid
M_AXIS_TLAST  out  1  last payload word of packet
M_AXIS_TREADY  in  1  master ready
ctrl  in  32  [0] enable, [1] soft reset, [2] passthrough, [3] stream-ID filter enable
streamID  in  32  expected stream ID when filter enabled
status  out  32  see Behaviour
timestamp_sec  out  32  integer timestamp of last accepted packet
timestamp_fsec  out  64  fractional timestamp of last accepted packet, {TSF0,TSF1}
trailer_out  out  32  last received trailer word
ts_valid  out  1  one-cycle pulse when timestamp_fsec updates

Behaviour:
- Reset: async assert clears state to S_HDR, output register, all counters, sticky bits and timestamp/trailer outputs (all 0); M_AXIS_TVALID=0, S_AXIS_TREADY=0, ts_valid=0.
- ctrl and streamID are registered every clock, so they take effect with 1-cycle latency.
- ctrl[1] (soft reset) is synchronous: state goes to S_HDR, the output register is flushed, sticky bits, packet counter and sequence reference are cleared. It applies mid-packet too.
- Every word is byte-swapped before parsing: w = {d[7:0],d[15:8],d[23:16],d[31:24]}.
- Header fields: type w[31:28], T w[26], TSI w[23:22] (11 = present, 00 = absent), TSF w[21:20], pkt_cnt w[19:16], size w[15:0] in words including the header.
- Payload length: plen = size − 2 − (TSI?1:0) − (TSF≠0?2:0) − (T?1:0), computed in 17-bit signed arithmetic.
- States:
  - S_HDR: S_AXIS_TREADY = enable. On a transfer, capture fields.
    - type≠PKT_TYPE or plen<1: set the matching sticky error, go to S_DROP.
    - Otherwise go to S_SID.
  - S_SID: ready=1. If filter enabled and word≠streamID: set sid_err, go to S_DROP. Else go to S_TSI if TSI present, else S_TSF0 if TSF≠0, else S_PAY.
  - S_TSI: ready=1; capture into a holding register, then go to S_TSF0/S_PAY.
  - S_TSF0, S_TSF1: ready=1; capture into holding registers. After TSF1, publish sec/fsec together, pulse ts_valid, go to S_PAY.
  - S_PAY: ready = !m_valid | M_AXIS_TREADY. Each transfer loads the output register; latency 1 cycle.
    - TLAST out=1 on word plen.
    - After word plen: go to S_TRL if T, else S_HDR.
  - S_TRL: ready=1; latch trailer_out, go to S_HDR.
  - S_DROP: ready=1; discard words until S_AXIS_TLAST, then go to S_HDR.
- Framing checks:
  - S_AXIS_TLAST before the final expected word: short_err. If in S_PAY, that word is emitted with M_AXIS_TLAST=1. Go to S_HDR.
  - Final expected word without S_AXIS_TLAST: long_err, go to S_DROP.
- Sequence check: the first accepted header after reset/soft reset sets the reference. Each later accepted header with pkt_cnt≠(ref+1) mod 16 sets seq_err; the reference always updates to the received pkt_cnt.
- Completed good packets increment rx_count (16-bit, wraps at 0xFFFF→0).
- Disable (ctrl[0]=0) takes effect only in S_HDR; a packet in progress completes.
- Passthrough (ctrl[2]=1), sampled in S_HDR: the packet is forwarded raw (no swap, no strip) through the output register, with TLAST copied; no checks.
- status = {rx_count[15:0], 3'b0, sid_err, type_err, long_err, short_err, seq_err, last_pkt_cnt[3:0], state[3:0]}. Error bits are sticky.
- Master holds TDATA/TLAST stable while TVALID=1 and TREADY=0.

Test Plan:
- Header wire 0x0800D010 (0x10D00008: TSI, TSF, size 8), SID, TSI 0x11223344, TSF 0xAABBCCDD/0x01020304, 3 payload, TLAST on word 8 → 3 swapped payload words, TLAST on 3rd; timestamp_sec=0x44332211; ts_valid one pulse.
- Same with T=1 (header 0x14D00008), TLAST on trailer → 2 payload words, TLAST on 2nd; trailer_out latched; no M beat for trailer.
- Back-to-back packets with pkt_cnt 0,1,3 → seq_err set after third; rx_count=3.
- M_AXIS_TREADY toggled 1-0 every cycle during payload → no loss or duplication; S_AXIS_TREADY deasserts when the output register is full.
- S_AXIS_TLAST on payload word 2 of 3 → short_err=1, M TLAST on word 2, next packet parsed correctly; then a size-8 packet with TLAST late on word 10 → long_err, extra words dropped.
- Filter on, streamID=0x5A, packet SID 0x5B → no M beats, sid_err=1; soft reset mid-payload → state 0, status bits cleared, M_AXIS_TVALID=0 next cycle.

Source files
------------

// File: rtl/vita49_unpack.sv
// VITA49 IF Data (with stream ID) receive parser: strips header, stream ID, timestamps and
// trailer, forwards byte-swapped payload and reports timestamps and framing status.
module vita49_unpack #(
  parameter logic [3:0] PKT_TYPE = 4'b0001
) (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESETN,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  input  logic        S_AXIS_TLAST,
  output logic        S_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY,
  input  logic [31:0] ctrl,
  input  logic [31:0] streamID,
  output logic [31:0] status,
  output logic [31:0] timestamp_sec,
  output logic [63:0] timestamp_fsec,
  output logic [31:0] trailer_out,
  output logic        ts_valid
);

  typedef enum logic [3:0] {
    StHdr  = 4'd0,
    StSid  = 4'd1,
    StTsi  = 4'd2,
    StTsf0 = 4'd3,
    StTsf1 = 4'd4,
    StPay  = 4'd5,
    StTrl  = 4'd6,
    StDrop = 4'd7,
    StPass = 4'd8
  } state_e;

  localparam int unsigned ErrSeq   = 0;
  localparam int unsigned ErrShort = 1;
  localparam int unsigned ErrLong  = 2;
  localparam int unsigned ErrType  = 3;
  localparam int unsigned ErrSid   = 4;

  state_e      state_q;
  logic [3:0]  ctrl_q;
  logic [31:0] sid_q;
  logic        m_valid_q, m_last_q;
  logic [31:0] m_data_q;
  logic [15:0] cnt_q, size_q, pay_end_q, rx_count_q;
  logic        t_q, tsi_q, tsf_q;
  logic [31:0] tsi_hold_q, tsf0_hold_q;
  logic        seq_vld_q;
  logic [3:0]  seq_ref_q;
  logic [4:0]  err_q;
  logic [31:0] ts_sec_q, trl_q;
  logic [63:0] ts_fsec_q;
  logic        ts_valid_q;

  logic        enable, soft_rst, pass, filt;
  logic        unused_ctrl;
  logic [31:0] w;
  logic [3:0]  h_type, h_pkt;
  logic        h_t, h_tsi, h_tsf;
  logic [15:0] h_size;
  logic [16:0] plen;
  logic        plen_bad, s_ready, s_xfer, out_free, last_exp, last_pay;
  logic [3:0]  state_bits;
  state_e      after_sid, after_tsi;

  assign enable      = ctrl_q[0];
  assign soft_rst    = ctrl_q[1];
  assign pass        = ctrl_q[2];
  assign filt        = ctrl_q[3];
  assign unused_ctrl = ^ctrl[31:4];

  assign w      = {S_AXIS_TDATA[7:0], S_AXIS_TDATA[15:8], S_AXIS_TDATA[23:16], S_AXIS_TDATA[31:24]};
  assign h_type = w[31:28];
  assign h_t    = w[26];
  assign h_tsi  = (w[23:22] != 2'b00);
  assign h_tsf  = (w[21:20] != 2'b00);
  assign h_pkt  = w[19:16];
  assign h_size = w[15:0];

  // 17-bit two's complement: bit 16 set means the header overhead exceeds size.
  assign plen     = {1'b0, h_size} - 17'd2 - {16'd0, h_tsi} - {15'd0, h_tsf, 1'b0} - {16'd0, h_t};
  assign plen_bad = plen[16] | (plen == 17'd0);

  assign out_free = !m_valid_q | M_AXIS_TREADY;
  assign last_exp = (cnt_q == size_q);
  assign last_pay = (cnt_q == pay_end_q);
  assign s_xfer   = S_AXIS_TVALID & s_ready;

  always_comb begin
    after_tsi = tsf_q ? StTsf0 : StPay;
    after_sid = tsi_q ? StTsi : after_tsi;
  end

  always_comb begin
    s_ready = 1'b1;
    case (state_q)
      StHdr:         s_ready = enable & (!pass | out_free);
      StPay, StPass: s_ready = out_free;
      default:       s_ready = 1'b1;
    endcase
    if (soft_rst) s_ready = 1'b0;
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      ctrl_q      <= '0;
      sid_q       <= '0;
      state_q     <= StHdr;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      cnt_q       <= '0;
      size_q      <= '0;
      pay_end_q   <= '0;
      t_q         <= 1'b0;
      tsi_q       <= 1'b0;
      tsf_q       <= 1'b0;
      tsi_hold_q  <= '0;
      tsf0_hold_q <= '0;
      seq_vld_q   <= 1'b0;
      seq_ref_q   <= '0;
      err_q       <= '0;
      rx_count_q  <= '0;
      ts_sec_q    <= '0;
      ts_fsec_q   <= '0;
      trl_q       <= '0;
      ts_valid_q  <= 1'b0;
    end else begin
      ctrl_q     <= ctrl[3:0];
      sid_q      <= streamID;
      ts_valid_q <= 1'b0;
      if (M_AXIS_TREADY) m_valid_q <= 1'b0;
      if (soft_rst) begin
        state_q    <= StHdr;
        m_valid_q  <= 1'b0;
        m_last_q   <= 1'b0;
        m_data_q   <= '0;
        err_q      <= '0;
        rx_count_q <= '0;
        seq_vld_q  <= 1'b0;
        seq_ref_q  <= '0;
      end else if (s_xfer) begin
        cnt_q <= cnt_q + 16'd1;
        case (state_q)
          StHdr: begin
            if (pass) begin
              m_valid_q <= 1'b1;
              m_data_q  <= S_AXIS_TDATA;
              m_last_q  <= S_AXIS_TLAST;
              state_q   <= S_AXIS_TLAST ? StHdr : StPass;
            end else begin
              cnt_q      <= 16'd2;
              size_q     <= h_size;
              pay_end_q  <= h_size - {15'd0, h_t};
              t_q        <= h_t;
              tsi_q      <= h_tsi;
              tsf_q      <= h_tsf;
              tsi_hold_q <= '0;
              if (h_type != PKT_TYPE) begin
                err_q[ErrType] <= 1'b1;
                state_q        <= S_AXIS_TLAST ? StHdr : StDrop;
              end else if (plen_bad) begin
                err_q[ErrShort] <= 1'b1;
                state_q         <= S_AXIS_TLAST ? StHdr : StDrop;
              end else begin
                if (seq_vld_q && (h_pkt != seq_ref_q + 4'd1)) err_q[ErrSeq] <= 1'b1;
                seq_ref_q <= h_pkt;
                seq_vld_q <= 1'b1;
                if (S_AXIS_TLAST) begin
                  err_q[ErrShort] <= 1'b1;
                  state_q         <= StHdr;
                end else begin
                  state_q <= StSid;
                end
              end
            end
          end
          StSid: begin
            if (S_AXIS_TLAST) begin
              err_q[ErrShort] <= 1'b1;
              state_q         <= StHdr;
            end else if (filt && (w != sid_q)) begin
              err_q[ErrSid] <= 1'b1;
              state_q       <= StDrop;
            end else begin
              state_q <= after_sid;
            end
          end
          StTsi: begin
            tsi_hold_q <= w;
            if (S_AXIS_TLAST) begin
              err_q[ErrShort] <= 1'b1;
              state_q         <= StHdr;
            end else begin
              state_q <= after_tsi;
            end
          end
          StTsf0: begin
            tsf0_hold_q <= w;
            if (S_AXIS_TLAST) begin
              err_q[ErrShort] <= 1'b1;
              state_q         <= StHdr;
            end else begin
              state_q <= StTsf1;
            end
          end
          StTsf1: begin
            if (S_AXIS_TLAST) begin
              err_q[ErrShort] <= 1'b1;
              state_q         <= StHdr;
            end else begin
              ts_sec_q   <= tsi_hold_q;
              ts_fsec_q  <= {tsf0_hold_q, w};
              ts_valid_q <= 1'b1;
              state_q    <= StPay;
            end
          end
          StPay: begin
            m_valid_q <= 1'b1;
            m_data_q  <= w;
            m_last_q  <= last_pay | S_AXIS_TLAST;
            if (S_AXIS_TLAST && !last_exp) begin
              err_q[ErrShort] <= 1'b1;
              state_q         <= StHdr;
            end else if (last_exp && !S_AXIS_TLAST) begin
              err_q[ErrLong] <= 1'b1;
              state_q        <= StDrop;
            end else if (last_pay) begin
              if (t_q) begin
                state_q <= StTrl;
              end else begin
                rx_count_q <= rx_count_q + 16'd1;
                state_q    <= StHdr;
              end
            end
          end
          StTrl: begin
            trl_q <= w;
            if (S_AXIS_TLAST) begin
              rx_count_q <= rx_count_q + 16'd1;
              state_q    <= StHdr;
            end else begin
              err_q[ErrLong] <= 1'b1;
              state_q        <= StDrop;
            end
          end
          StDrop: begin
            if (S_AXIS_TLAST) state_q <= StHdr;
          end
          StPass: begin
            m_valid_q <= 1'b1;
            m_data_q  <= S_AXIS_TDATA;
            m_last_q  <= S_AXIS_TLAST;
            if (S_AXIS_TLAST) state_q <= StHdr;
          end
          default: state_q <= StHdr;
        endcase
      end
    end
  end

  assign state_bits     = state_q;
  assign S_AXIS_TREADY  = s_ready;
  assign M_AXIS_TDATA   = m_data_q;
  assign M_AXIS_TVALID  = m_valid_q;
  assign M_AXIS_TLAST   = m_last_q;
  assign status         = {rx_count_q, 3'b000, err_q, seq_ref_q, state_bits};
  assign timestamp_sec  = ts_sec_q;
  assign timestamp_fsec = ts_fsec_q;
  assign trailer_out    = trl_q;
  assign ts_valid       = ts_valid_q;

endmodule

// File: tb/tb_vita49_unpack.sv
// Randomized bench for vita49_unpack with a packet-level reference model and scoreboard.
module tb_vita49_unpack;

  typedef logic [31:0] wq_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] S_AXIS_TDATA;
  logic        S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TREADY;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
  logic [31:0] ctrl, streamID, status, timestamp_sec, trailer_out;
  logic [63:0] timestamp_fsec;
  logic        ts_valid;

  vita49_unpack #(.PKT_TYPE(4'b0001)) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rst_n),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .ctrl          (ctrl),
    .streamID      (streamID),
    .status        (status),
    .timestamp_sec (timestamp_sec),
    .timestamp_fsec(timestamp_fsec),
    .trailer_out   (trailer_out),
    .ts_valid      (ts_valid)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  // Reference model state: {sid,type,long,short,seq} error bits, counters, published values.
  logic [15:0] m_rx = '0;
  logic [4:0]  m_err = '0;
  logic        m_seqv = 1'b0;
  logic [3:0]  m_ref = '0;
  logic [31:0] m_sec = '0, m_trl = '0, m_sid = '0;
  logic [63:0] m_fsec = '0;
  logic        m_pass = 1'b0, m_filt = 1'b0;
  int          m_pulses = 0, pulses = 0;
  int          mready_mode = 0;
  bit          hold_en = 1'b1;
  bit          stall_q = 1'b0;
  logic [32:0] prev_beat = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  always @(negedge clk) begin
    if (hold_en && stall_q)
      check_eq("m_hold", {31'd0, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA}, {31'd0, 1'b1, prev_beat});
    stall_q   = M_AXIS_TVALID && !M_AXIS_TREADY;
    prev_beat = {M_AXIS_TLAST, M_AXIS_TDATA};
    if (M_AXIS_TVALID && M_AXIS_TREADY) got_q.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
    if (ts_valid) pulses++;
  end

  initial begin
    M_AXIS_TREADY = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mready_mode)
        0:       M_AXIS_TREADY = 1'b1;
        1:       M_AXIS_TREADY = ~M_AXIS_TREADY;
        2:       M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
        default: M_AXIS_TREADY = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic build(output wq_t p, input logic [3:0] typ, input bit t, input bit tsi,
                       input bit tsf, input logic [3:0] pc, input logic [15:0] size,
                       input logic [31:0] sid, input int n);
    logic [31:0] h;
    h = {typ, 1'b0, t, 2'b00, tsi ? 2'b11 : 2'b00, tsf ? 2'b01 : 2'b00, pc, size};
    p = {};
    p.push_back(swap32(h));
    if (n > 1) p.push_back(swap32(sid));
    for (int i = 2; i < n; i++) p.push_back($urandom);
  endtask

  // Packet-level expectation: payload sits at [hl, hl+plen), trailer (if any) right after.
  task automatic model_pkt(input wq_t p);
    logic [31:0] w;
    int n, hl, plen, m, t, tsi, tsf, size;
    logic [3:0] pc;
    n = p.size();
    if (m_pass) begin
      for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, p[i]});
      return;
    end
    w    = swap32(p[0]);
    t    = int'(w[26]);
    tsi  = (w[23:22] != 2'b00) ? 1 : 0;
    tsf  = (w[21:20] != 2'b00) ? 1 : 0;
    pc   = w[19:16];
    size = int'(w[15:0]);
    hl   = 2 + tsi + 2 * tsf;
    plen = size - hl - t;
    if (w[31:28] != 4'b0001) begin m_err[3] = 1'b1; return; end
    if (plen < 1) begin m_err[1] = 1'b1; return; end
    if (m_seqv && pc != 4'(m_ref + 4'd1)) m_err[0] = 1'b1;
    m_ref  = pc;
    m_seqv = 1'b1;
    if (n <= 2) begin m_err[1] = 1'b1; return; end
    if (m_filt && swap32(p[1]) != m_sid) begin m_err[4] = 1'b1; return; end
    if (n <= hl) begin m_err[1] = 1'b1; return; end
    if (tsf == 1) begin
      m_sec  = (tsi == 1) ? swap32(p[2]) : 32'd0;
      m_fsec = {swap32(p[2 + tsi]), swap32(p[3 + tsi])};
      m_pulses++;
    end
    m = (n - hl < plen) ? n - hl : plen;
    for (int k = 0; k < m; k++) exp_q.push_back({k == m - 1, swap32(p[hl + k])});
    if (n - hl < plen) m_err[1] = 1'b1;
    else if (n - hl == plen) begin
      if (t == 1) m_err[1] = 1'b1;
      else m_rx++;
    end else if (t == 0) m_err[2] = 1'b1;
    else begin
      m_trl = swap32(p[hl + plen]);
      if (n == size) m_rx++;
      else m_err[2] = 1'b1;
    end
  endtask

  task automatic send(input wq_t p, input bit tlast_end);
    int  g;
    bit  ok;
    for (int i = 0; i < p.size(); i++) begin
      S_AXIS_TDATA  = p[i];
      S_AXIS_TLAST  = tlast_end && (i == p.size() - 1);
      S_AXIS_TVALID = 1'b1;
      g  = 0;
      ok = 1'b0;
      while (!ok && g < 500) begin
        @(negedge clk);
        ok = S_AXIS_TREADY;
        @(posedge clk); #1;
        g++;
      end
      if (!ok) begin
        check_eq("s_ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (M_AXIS_TVALID && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 500) check_eq("drain_timeout", 64'd0, 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic [31:0] c, input logic [31:0] sid);
    ctrl     = c;
    streamID = sid;
    repeat (2) @(posedge clk);
    #1;
    m_pass = c[2];
    m_filt = c[3];
    m_sid  = sid;
  endtask

  task automatic full_check(input string tag);
    int n;
    check_eq({tag, ":nbeats"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({tag, ":beat"}, 64'(got_q[i]), 64'(exp_q[i]));
    check_eq({tag, ":status"}, 64'(status), 64'({m_rx, 3'b000, m_err, m_ref, 4'h0}));
    check_eq({tag, ":ts_sec"}, 64'(timestamp_sec), 64'(m_sec));
    check_eq({tag, ":ts_fsec"}, timestamp_fsec, m_fsec);
    check_eq({tag, ":trailer"}, 64'(trailer_out), 64'(m_trl));
    check_eq({tag, ":ts_pulses"}, 64'(pulses), 64'(m_pulses));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic run_pkt(input wq_t p, input string tag);
    model_pkt(p);
    send(p, 1'b1);
    drain();
    full_check(tag);
  endtask

  initial begin
    wq_t p, q;
    logic [3:0]  typ, pc;
    bit          t, tsi, tsf, pass, filt;
    int          plen, hl, size, n, frame;
    logic [31:0] sidv, sw;

    rst_n = 1'b0;
    ctrl = '0;
    streamID = '0;
    S_AXIS_TDATA = '0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_status", 64'(status), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_mvalid", 64'(M_AXIS_TVALID), 64'd0);
    check_eq("rst_sready", 64'(S_AXIS_TREADY), 64'd0);
    check_eq("rst_tsvalid", 64'(ts_valid), 64'd0);
    check_eq("rst_ts", {32'd0, timestamp_sec | trailer_out}, 64'd0);
    check_eq("rst_fsec", timestamp_fsec, 64'd0);

    set_ctrl(32'h1, 32'h0);

    // Directed: TSI+TSF, 3 payload words.
    build(p, 4'd1, 1'b0, 1'b1, 1'b1, 4'd0, 16'd8, 32'h5A, 8);
    p[2] = 32'h11223344;
    p[3] = 32'hAABBCCDD;
    p[4] = 32'h01020304;
    check_eq("hdr_wire", 64'(p[0]), 64'h0800D010);
    run_pkt(p, "d_basic");
    check_eq("d_basic_sec", 64'(timestamp_sec), 64'h44332211);
    check_eq("d_basic_fsec", timestamp_fsec, 64'hDDCCBBAA_04030201);

    // Directed: with trailer.
    build(p, 4'd1, 1'b1, 1'b1, 1'b1, 4'd1, 16'd8, 32'h5A, 8);
    run_pkt(p, "d_trailer");

    // Directed: sequence gap 1 -> 3.
    build(p, 4'd1, 1'b0, 1'b0, 1'b0, 4'd3, 16'd5, 32'h5A, 5);
    run_pkt(p, "d_seq");
    check_eq("d_seq_err", 64'(status[8]), 64'd1);
    check_eq("d_seq_rx", 64'(status[31:16]), 64'd3);

    // Directed: master ready toggling every cycle.
    mready_mode = 1;
    build(p, 4'd1, 1'b0, 1'b0, 1'b0, 4'd4, 16'd8, 32'h5A, 8);
    run_pkt(p, "d_toggle");
    mready_mode = 0;

    // Directed: early TLAST, recovery, then late TLAST.
    build(p, 4'd1, 1'b0, 1'b1, 1'b1, 4'd5, 16'd8, 32'h5A, 7);
    run_pkt(p, "d_short");
    check_eq("d_short_err", 64'(status[9]), 64'd1);
    build(p, 4'd1, 1'b0, 1'b0, 1'b0, 4'd6, 16'd4, 32'h5A, 4);
    run_pkt(p, "d_after_short");
    build(p, 4'd1, 1'b0, 1'b1, 1'b1, 4'd7, 16'd8, 32'h5A, 10);
    run_pkt(p, "d_long");
    check_eq("d_long_err", 64'(status[10]), 64'd1);

    // Directed: stream-ID filter mismatch.
    set_ctrl(32'h9, 32'h5A);
    build(p, 4'd1, 1'b0, 1'b0, 1'b0, 4'd8, 16'd5, 32'h5B, 5);
    run_pkt(p, "d_filter");
    check_eq("d_sid_err", 64'(status[12]), 64'd1);

    // Directed: backpressure fills the output register, then soft reset mid-payload.
    set_ctrl(32'h1, 32'h5A);
    mready_mode = 3;
    repeat (2) @(posedge clk);
    #1;
    build(p, 4'd1, 1'b0, 1'b1, 1'b1, 4'(m_ref + 4'd1), 16'd8, 32'h5A, 8);
    q = p[0:5];
    send(q, 1'b0);
    S_AXIS_TDATA  = p[6];
    S_AXIS_TVALID = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("full_sready", 64'(S_AXIS_TREADY), 64'd0);
    check_eq("full_mdata", {31'd0, M_AXIS_TVALID, M_AXIS_TDATA}, {31'd0, 1'b1, swap32(p[5])});
    @(posedge clk); #1;
    S_AXIS_TVALID = 1'b0;
    hold_en = 1'b0;
    ctrl = 32'h3;
    repeat (2) @(posedge clk);
    #1;
    check_eq("srst_status", 64'(status), 64'd0);
    check_eq("srst_mvalid", 64'(M_AXIS_TVALID), 64'd0);
    m_sec  = swap32(p[2]);
    m_fsec = {swap32(p[3]), swap32(p[4])};
    m_pulses++;
    m_err  = '0;
    m_rx   = '0;
    m_seqv = 1'b0;
    m_ref  = '0;
    set_ctrl(32'h1, 32'h5A);
    hold_en = 1'b1;
    mready_mode = 0;
    full_check("d_srst");
    build(p, 4'd1, 1'b1, 1'b0, 1'b1, 4'd9, 16'd7, 32'h5A, 7);
    run_pkt(p, "d_after_srst");

    // Randomized packets.
    for (int r = 0; r < 60; r++) begin
      pass = ($urandom_range(0, 9) == 0);
      filt = ($urandom_range(0, 4) == 0);
      sidv = ($urandom_range(0, 3) == 0) ? $urandom : 32'h5A;
      set_ctrl({28'd0, filt, pass, 1'b0, 1'b1}, sidv);
      mready_mode = $urandom_range(0, 2);
      typ  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 15)) : 4'd1;
      t    = $urandom_range(0, 1) == 1;
      tsi  = $urandom_range(0, 1) == 1;
      tsf  = $urandom_range(0, 1) == 1;
      plen = $urandom_range(1, 6);
      hl   = 2 + (tsi ? 1 : 0) + (tsf ? 2 : 0);
      size = hl + plen + (t ? 1 : 0);
      if ($urandom_range(0, 9) == 0) size = $urandom_range(1, hl + (t ? 1 : 0));
      pc = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'(m_ref + 4'd1);
      frame = $urandom_range(0, 5);
      if (frame == 0) n = (size > 1) ? $urandom_range(1, size - 1) : 1;
      else if (frame == 1) n = size + $urandom_range(1, 3);
      else n = size;
      sw = (filt && $urandom_range(0, 1) == 1) ? sidv : $urandom;
      build(p, typ, t, tsi, tsf, pc, 16'(size), sw, n);
      run_pkt(p, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
